// File: rtl/risc16_trace_capture.sv
// risc16_trace_capture: armed PC-trigger trace buffer draining {pc, instr} records over valid/ready
module risc16_trace_capture #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic [15:0]      trig_pc,
    input  logic [CNT_W-1:0] post_count,
    input  logic [15:0]      curr_pc,
    input  logic [15:0]      curr_instr,
    output logic             tr_valid,
    input  logic             tr_ready,
    output logic [31:0]      tr_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TRIG, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] dropped_q, dropped_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    vis_ptr_q, vis_ptr_d;
    logic [31:0]      mem_q [DEPTH];
    logic             capture, full, pop, push;
    logic [AW-1:0]    waddr;

    // Session FSM, trigger countdown and FIFO pointer/drop bookkeeping.
    // vis_ptr lags wr_ptr by one cycle so a new record becomes visible one edge after capture.
    always_comb begin
        capture   = arm || state_q == S_ARMED || state_q == S_TRIG;
        full      = wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0] && wr_ptr_q[AW] != rd_ptr_q[AW];
        tr_valid  = vis_ptr_q != rd_ptr_q;
        tr_data   = tr_valid ? mem_q[rd_ptr_q[AW-1:0]] : 32'h0;
        pop       = tr_valid && tr_ready && !arm;
        push      = capture && (arm || !full || pop);
        waddr     = arm ? '0 : wr_ptr_q[AW-1:0];
        wr_ptr_d  = arm ? PW'(1) : wr_ptr_q + PW'(push);
        rd_ptr_d  = arm ? '0 : rd_ptr_q + PW'(pop);
        vis_ptr_d = arm ? '0 : wr_ptr_q;
        dropped_d = arm ? '0 :
                    (capture && !push && dropped_q != '1) ? dropped_q + CNT_W'(1) : dropped_q;
        state_d   = state_q;
        rem_d     = rem_q;
        if (arm || state_q == S_ARMED) begin
            state_d = curr_pc != trig_pc ? S_ARMED : post_count == '0 ? S_DONE : S_TRIG;
            rem_d   = post_count;
        end else if (state_q == S_TRIG) begin
            state_d = rem_q == CNT_W'(1) ? S_DONE : S_TRIG;
            rem_d   = rem_q - CNT_W'(1);
        end
        busy    = state_q == S_ARMED || state_q == S_TRIG;
        done    = state_q == S_DONE;
        dropped = dropped_q;
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            dropped_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            vis_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            dropped_q <= dropped_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            vis_ptr_q <= vis_ptr_d;
        end
    end

    // Record storage; contents are only observable through valid pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[waddr] <= {curr_pc, curr_instr};
    end
endmodule

// File: tb/tb_risc16_trace_capture.sv
// tb_risc16_trace_capture: directed-vector bench for the trace capture block
module tb_risc16_trace_capture;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        arm = 1'b0;
    logic        tr_ready = 1'b0;
    logic [15:0] trig_pc = 16'h0;
    logic [15:0] post_count = 16'h0;
    logic [15:0] curr_pc = 16'h0;
    logic [15:0] curr_instr = 16'h0;
    logic        tr_valid, busy, done;
    logic [31:0] tr_data;
    logic [15:0] dropped;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] got [$];
    logic [31:0] exp_q [$];

    risc16_trace_capture #(.DEPTH(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .arm(arm), .trig_pc(trig_pc), .post_count(post_count),
        .curr_pc(curr_pc), .curr_instr(curr_instr), .tr_valid(tr_valid), .tr_ready(tr_ready),
        .tr_data(tr_data), .busy(busy), .done(done), .dropped(dropped)
    );

    always #5 clk = ~clk;

    // Records accepted by the sink, sampled mid-cycle ahead of the popping edge.
    always @(negedge clk) begin
        if (reset && tr_valid && tr_ready) got.push_back(tr_data);
    end

    function automatic logic [15:0] ins(input logic [15:0] pc);
        return pc ^ 16'hC3A5;
    endfunction

    function automatic logic [31:0] rec(input logic [15:0] pc);
        return {pc, ins(pc)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cmp_recs(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), i < got.size() ? got[i] : 32'hxxxxxxxx, exp_q[i]);
    endtask

    task automatic drive(input logic [15:0] pc);
        curr_pc = pc;
        curr_instr = ins(pc);
        @(posedge clk);
        #1;
        arm = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_valid", tr_valid, 0);
        chk("rst_data", tr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dropped", dropped, 0);
        #9 reset = 1'b1;
        for (int p = 0; p <= 20; p++) begin
            drive(16'(p));
            chk("idle_valid", tr_valid, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_dropped", dropped, 0);
        end

        got.delete();
        trig_pc = 16'd5; post_count = 16'd2; tr_ready = 1'b1; arm = 1'b1;
        for (int p = 0; p <= 11; p++) begin
            drive(16'(p));
            if (p == 0) chk("bt_busy", busy, 1);
            if (p == 6) chk("bt_done6", done, 0);
            if (p == 7) chk("bt_done7", done, 1);
        end
        exp_q.delete();
        for (int p = 0; p <= 7; p++) exp_q.push_back(rec(16'(p)));
        cmp_recs("bt");

        got.delete();
        trig_pc = 16'd40; post_count = 16'd0; arm = 1'b1;
        drive(16'd40);
        chk("imm_done", done, 1);
        chk("imm_busy", busy, 0);
        for (int p = 41; p <= 44; p++) drive(16'(p));
        exp_q.delete();
        exp_q.push_back(rec(16'd40));
        cmp_recs("imm");

        got.delete();
        tr_ready = 1'b0; trig_pc = 16'hFFFF; arm = 1'b1;
        for (int p = 0; p <= 19; p++) begin
            drive(16'(p));
            if (p >= 1) chk("bp_stall_data", tr_data, rec(16'd0));
        end
        chk("bp_valid", tr_valid, 1);
        chk("bp_dropped", dropped, 4);
        chk("bp_busy", busy, 1);
        trig_pc = 16'd20; tr_ready = 1'b1;
        drive(16'd20);
        tr_ready = 1'b0;
        chk("fp_nodrop", dropped, 4);
        chk("fp_done", done, 1);
        tr_ready = 1'b1;
        for (int p = 21; p <= 40; p++) drive(16'(p));
        exp_q.delete();
        for (int p = 0; p <= 15; p++) exp_q.push_back(rec(16'(p)));
        exp_q.push_back(rec(16'd20));
        cmp_recs("bp");

        got.delete();
        trig_pc = 16'd102; post_count = 16'd50; arm = 1'b1;
        for (int p = 100; p <= 103; p++) drive(16'(p));
        chk("rr_pre_busy", busy, 1);
        chk("rr_pre_valid", tr_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("rr_async_valid", tr_valid, 0);
        chk("rr_async_busy", busy, 0);
        chk("rr_async_done", done, 0);
        chk("rr_async_data", tr_data, 0);
        #3 reset = 1'b1;
        got.delete();
        drive(16'd150);
        chk("rr_idle_busy", busy, 0);
        chk("rr_idle_valid", tr_valid, 0);
        trig_pc = 16'd203; post_count = 16'd1; arm = 1'b1;
        for (int p = 200; p <= 210; p++) begin
            drive(16'(p));
            if (p == 203) chk("rr_done203", done, 0);
            if (p == 204) chk("rr_done204", done, 1);
        end
        chk("rr_dropped", dropped, 0);
        exp_q.delete();
        for (int p = 200; p <= 204; p++) exp_q.push_back(rec(16'(p)));
        cmp_recs("rr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/risc16_trace_capture.md
Name: risc16_trace_capture

Overview:
- Consumes the RiSC-16 core's per-cycle observation outputs (curr_pc, curr_instr) and buffers {pc, instr} trace records in an on-chip FIFO.
- Drains the records over a valid/ready stream to a debug or host sink.
- Sits beside the top-level core and replaces the simulation-only $display monitor with synthesizable trace capture.
- Supports arm, PC-match trigger, post-trigger record count and overflow accounting.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the post_count input and the drop counter.

Ports:
- clk  input  1  rising-edge clock, same clock as the core.
- reset  input  1  asynchronous, active-low reset.
- arm  input  1  one-cycle pulse; starts a capture session.
- trig_pc  input  16  PC value that fires the trigger.
- post_count  input  CNT_W  number of records to keep after the trigger record; 0 means stop at the trigger record.
- curr_pc  input  16  core PC for the current cycle.
- curr_instr  input  16  core instruction for the current cycle.
- tr_valid  output  1  trace record available.
- tr_ready  input  1  sink accepts the record.
- tr_data  output  32  {pc[31:16], instr[15:0]}.
- busy  output  1  high in ARMED or TRIGGERED.
- done  output  1  high in DONE.
- dropped  output  CNT_W  count of records lost to a full FIFO; saturating.

Behaviour:
- Reset (reset=0, asynchronous): the state goes to IDLE and the FIFO empties.
  - Outputs take tr_valid=0, tr_data=0, busy=0, done=0, dropped=0.
  - Reset applied mid-session discards all contents and the session.
- States:
  - IDLE: nothing is captured. arm moves the block to ARMED.
  - ARMED: a record is captured every cycle. If curr_pc==trig_pc in that cycle, the record is captured, the remaining count is loaded with post_count, and the block moves to TRIGGERED. If post_count==0, it moves straight to DONE instead.
  - TRIGGERED: a record is captured every cycle and the remaining count decrements per captured cycle. The cycle that captures with remaining==1 moves the block to DONE. Further PC matches are ignored.
  - DONE: no capture; the FIFO keeps draining. arm returns the block to ARMED.
- Capture is sampled on the rising edge. A record captured at edge N is visible on tr_valid/tr_data no earlier than after edge N+1, so the FIFO-to-output latency is 1 cycle.
- On the arm cycle:
  - Entering ARMED clears dropped and flushes the FIFO.
  - The arm cycle itself also captures.
  - arm while busy restarts the session with the same flush and clear.
- Full FIFO:
  - A capture attempt when the FIFO is full and no pop occurs in the same cycle is dropped.
  - dropped increments and saturates at all-ones.
  - The trigger and post-count logic still advance; a dropped cycle counts toward post_count.
- Simultaneous push and pop when full: the pop frees a slot and the push succeeds, with no drop.
- Stream handshake:
  - Pop occurs when tr_valid && tr_ready.
  - tr_data must hold stable while tr_valid=1 and tr_ready=0.
  - tr_valid never drops without a pop, except on reset or on an arm flush.
- Pointers are log2(DEPTH)+1 bits with wrap bit. Full is indicated by equal indices with differing wrap bits; empty by pointers being equal.

Test Plan:
- Reset idle:
  - Stimulus: reset=0 then 1; no arm; the core runs PC 0..20.
  - Required: tr_valid=0, busy=0, done=0 and dropped=0 throughout.
- Basic trigger:
  - Stimulus: arm at PC=0; trig_pc=5; post_count=2; tr_ready=1; PC increments each cycle.
  - Required: exactly 8 records with pc 0..7 in order, each carrying the matching instr; done=1 after the PC=7 cycle.
- Immediate stop:
  - Stimulus: trig_pc equals the PC on the arm cycle; post_count=0.
  - Required: one record is emitted and done=1 on the next cycle.
- Backpressure and overflow:
  - Stimulus: DEPTH=16; tr_ready=0; arm; trig_pc never matches; run 20 cycles.
  - Required: the FIFO holds pc 0..15 and dropped=4. Then tr_ready=1: the next 16 records are pc 0..15 and tr_data stays stable while stalled.
- Full with simultaneous pop:
  - Stimulus: FIFO full; tr_ready pulsed for 1 cycle while capture continues.
  - Required: no drop that cycle, and the record order is preserved.
- Reset and re-arm:
  - Stimulus: reset mid-TRIGGERED.
  - Required: tr_valid=0 and the state is IDLE immediately, asynchronously.
  - Stimulus: then arm, with trig_pc matching 3 cycles later and post_count=1.
  - Required: 5 records, dropped=0.
